// File: rtl/mpeg2_stream_pkg.sv
// rtl/mpeg2_stream_pkg.sv - shared types and constants for the MPEG-2 byte serializer
package mpeg2_stream_pkg;

    localparam int WORD_BITS  = 256;
    localparam int WORD_BYTES = 32;
    localparam int BYTE_IDX_W = 5;

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(WORD_BYTES - 1);

    typedef struct packed {
        logic                 last;
        logic [WORD_BITS-1:0] data;
    } word_t;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } ser_state_t;

endpackage

// File: rtl/mpeg2_word_fifo.sv
// rtl/mpeg2_word_fifo.sv - single-clock word FIFO, dout shows the head entry from registers
module mpeg2_word_fifo
    import mpeg2_stream_pkg::*;
#(
    parameter int DEPTH_L = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  word_t            din,
    output word_t            dout,
    output logic [DEPTH_L:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [DEPTH_L:0] FULL_CNT = {1'b1, {DEPTH_L{1'b0}}};

    word_t              mem [2**DEPTH_L];
    logic [DEPTH_L-1:0] wr_ptr;
    logic [DEPTH_L-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/mpeg2_stream_serializer.sv
// rtl/mpeg2_stream_serializer.sv - buffers 256-bit encoder words and emits them byte 0 first
module mpeg2_stream_serializer
    import mpeg2_stream_pkg::*;
#(
    parameter int DEPTH_L = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_en,
    input  logic                 i_last,
    input  logic [WORD_BITS-1:0] i_data,
    output logic                 o_tvalid,
    input  logic                 i_tready,
    output logic [7:0]           o_tdata,
    output logic                 o_tlast,
    output logic [DEPTH_L:0]     o_words,
    output logic                 o_overflow
);

    ser_state_t            state, state_nx;
    logic [WORD_BITS-1:0]  shift_data;
    logic                  shift_last;
    logic [BYTE_IDX_W-1:0] idx, idx_nx;
    logic                  overflow;

    logic  pop, push, load;
    logic  fifo_full, fifo_empty;
    word_t fifo_din, fifo_dout;

    assign fifo_din = '{last: i_last, data: i_data};
    // A full FIFO still takes the word when the same edge frees a slot.
    assign push     = i_en && (!fifo_full || pop);

    mpeg2_word_fifo #(.DEPTH_L(DEPTH_L)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (o_words),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        pop      = 1'b0;
        load     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    load     = 1'b1;
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_tready) begin
                    if (idx == LAST_IDX) begin
                        if (!fifo_empty) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (load) idx_nx = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            shift_data <= '0;
            shift_last <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            if (load) begin
                shift_data <= fifo_dout.data;
                shift_last <= fifo_dout.last;
            end
            if (i_en && !push) overflow <= 1'b1;
        end
    end

    assign o_tvalid   = (state == ST_SEND);
    assign o_tdata    = o_tvalid ? shift_data[{idx, 3'b000} +: 8] : 8'h00;
    assign o_tlast    = o_tvalid && shift_last && (idx == LAST_IDX);
    assign o_overflow = overflow;

endmodule

// File: tb/tb_mpeg2_stream_serializer.sv
// tb/tb_mpeg2_stream_serializer.sv - scoreboard bench for mpeg2_stream_serializer
module tb_mpeg2_stream_serializer;

    localparam int DEPTH_L = 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         i_en = 1'b0;
    logic         i_last = 1'b0;
    logic [255:0] i_data = '0;
    logic         o_tvalid;
    logic         i_tready = 1'b0;
    logic [7:0]   o_tdata;
    logic         o_tlast;
    logic [DEPTH_L:0] o_words;
    logic         o_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb_q [$];

    mpeg2_stream_serializer #(.DEPTH_L(DEPTH_L)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_en       (i_en),
        .i_last     (i_last),
        .i_data     (i_data),
        .o_tvalid   (o_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_words    (o_words),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] make_word(input logic [7:0] base);
        logic [255:0] w;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic sb_push(input logic [255:0] d, input logic last);
        for (int i = 0; i < 32; i++) sb_q.push_back({last && (i == 31), d[i*8 +: 8]});
    endtask

    // Drive one word for one edge; model its bytes only when it is expected to be kept.
    task automatic push_word(input logic [255:0] d, input logic last, input bit kept);
        i_en = 1'b1; i_data = d; i_last = last;
        if (kept) sb_push(d, last);
        @(posedge clk); #1;
        i_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int cyc = 0;
        while ((sb_q.size() != 0 || o_tvalid) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, (sb_q.size() == 0 && !o_tvalid), 1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_en = 1'b0; i_tready = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Monitor: compare each accepted byte against the model and hold steady during stalls.
    logic       stalled = 1'b0;
    logic [8:0] stall_val;
    always @(negedge clk) begin
        if (!rstn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", o_tvalid, 1);
                check("stall_data", {o_tlast, o_tdata}, stall_val);
            end
            stalled = 1'b0;
            if (o_tvalid && i_tready) begin
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("byte_data", o_tdata, e[7:0]);
                    check("byte_last", o_tlast, e[8]);
                end
            end else if (o_tvalid) begin
                stalled   = 1'b1;
                stall_val = {o_tlast, o_tdata};
            end
        end
    end

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [DEPTH_L:0] peak;
        logic [255:0] w;
        int cyc;

        #2;
        check("rst_tvalid", o_tvalid, 0);
        check("rst_tdata", o_tdata, 0);
        check("rst_tlast", o_tlast, 0);
        check("rst_words", o_words, 0);
        check("rst_overflow", o_overflow, 0);
        @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Single word, latency and drain
        i_tready = 1'b1;
        push_word(make_word(8'h00), 1'b1, 1);
        check("lat_valid_k", o_tvalid, 0);
        check("lat_words_k", o_words, 1);
        @(posedge clk); #1;
        check("lat_valid_k1", o_tvalid, 1);
        check("lat_byte0", o_tdata, 8'h00);
        wait_drain("single_drain", 100);
        check("single_words", o_words, 0);

        // Back-to-back words: 64 contiguous bytes, occupancy peaks at 1
        peak = '0;
        push_word(make_word(8'h40), 1'b0, 1);
        if (o_words > peak) peak = o_words;
        push_word(make_word(8'h80), 1'b1, 1);
        if (o_words > peak) peak = o_words;
        for (int i = 0; i < 63; i++) begin
            check("b2b_valid", o_tvalid, 1);
            @(posedge clk); #1;
            if (o_words > peak) peak = o_words;
        end
        check("b2b_valid_last", o_tvalid, 1);
        check("b2b_peak", peak, 1);
        wait_drain("b2b_drain", 10);

        // Backpressure 1,0,0,1
        i_tready = 1'b0;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        push_word(w, 1'b0, 1);
        cyc = 0;
        while ((sb_q.size() != 0 || o_tvalid) && cyc < 300) begin
            i_tready = pat[cyc % 4];
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_drain", (sb_q.size() == 0 && !o_tvalid), 1);

        // Overflow: shifter takes word 0, FIFO words 1-4, word 5 dropped
        do_reset();
        i_tready = 1'b0;
        for (int k = 0; k < 5; k++) push_word(make_word(8'(k * 32)), k == 4, 1);
        check("ovf_before", o_overflow, 0);
        check("ovf_words_full", o_words, 4);
        push_word(make_word(8'hA0), 1'b1, 0);
        check("ovf_flag", o_overflow, 1);
        check("ovf_words", o_words, 4);
        i_tready = 1'b1;
        wait_drain("ovf_drain", 400);
        check("ovf_sticky", o_overflow, 1);

        // Push at full coinciding with the byte-31 pop
        do_reset();
        i_tready = 1'b0;
        for (int k = 0; k < 5; k++) push_word(make_word(8'(k * 16 + 3)), 1'b0, 1);
        check("pf_words_full", o_words, 4);
        i_tready = 1'b1;
        repeat (31) begin @(posedge clk); #1; end
        push_word(make_word(8'h77), 1'b1, 1);
        check("pf_overflow", o_overflow, 0);
        check("pf_words", o_words, 4);
        wait_drain("pf_drain", 400);

        // Mid-word reset at byte 10
        do_reset();
        i_tready = 1'b1;
        push_word(make_word(8'h10), 1'b1, 1);
        repeat (11) begin @(posedge clk); #1; end
        check("mr_byte10", o_tdata, 8'h1A);
        #1 rstn = 1'b0;
        sb_q.delete();
        #1;
        check("mr_tvalid", o_tvalid, 0);
        check("mr_tdata", o_tdata, 0);
        check("mr_tlast", o_tlast, 0);
        check("mr_words", o_words, 0);
        check("mr_overflow", o_overflow, 0);
        @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
        @(posedge clk); #1;
        push_word(make_word(8'hC0), 1'b1, 1);
        wait_drain("mr_drain", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
